// File: rtl/tqvp_sprite_engine_multi.sv
// TinyQV sprite peripheral: NUM_SPR 8x8 1bpp sprites over scaled XGA timing, config shadowed and committed at vsync.
// Define SPRITE_COLLISION_EN to build the collision mask, coll_flag and its interrupt term.
module tqvp_sprite_engine_multi #(
    parameter int NUM_SPR    = 4,
    parameter int SCALE_LOG2 = 2,
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_COMMIT   = 10'(V_ACTIVE + V_FP);
    localparam logic [31:0] ATTR_MASK  = 32'h803F_FFFF;

    function automatic logic [31:0] size_mask(input logic [1:0] wn);
        logic [31:0] m;
        case (wn)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            2'b10:   m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [31:0] m);
        return (old & ~m) | (wdata & m);
    endfunction

    logic                 stream_en_r, vsync_irq_en_r, vsync_flag_r, commit_pending_r, vsync_d_r;
    logic [10:0]          h_cnt_r;
    logic [9:0]           v_cnt_r;
    logic [7:0]           uo_r;
    logic [31:0]          attr_sh_r [NUM_SPR];
    logic [31:0]          lo_sh_r   [NUM_SPR];
    logic [31:0]          hi_sh_r   [NUM_SPR];
    logic [22:0]          act_attr_r [NUM_SPR];
    logic [63:0]          act_bmp_r  [NUM_SPR];

    logic                 wr_s, sh_wr_s, commit_s, visible_s, vsync_set_s, vsync_clr_s;
    logic                 hs_s, vs_s, in_vblank_s, coll_flag_s, coll_irq_en_s, unused_s;
    logic [31:0]          wmask_s;
    logic [3:0]           word_s;
    logic [15:0]          wr_word_s;
    logic [31:0]          attr_nx_s [NUM_SPR];
    logic [31:0]          lo_nx_s   [NUM_SPR];
    logic [31:0]          hi_nx_s   [NUM_SPR];
    logic [8:0]           lx_s, ly_s;
    logic [8:0]           dx_s [NUM_SPR];
    logic [8:0]           dy_s [NUM_SPR];
    logic [NUM_SPR-1:0]   hit_s, coll_mask_s;
    logic [5:0]           rgb_s, pix_rgb_s;
    logic [31:0]          reg_word_s [16];

    assign wr_s        = (data_write_n != 2'b11);
    assign wmask_s     = size_mask(data_write_n);
    assign word_s      = address[5:2];
    assign wr_word_s   = wr_s ? (16'h0001 << word_s) : 16'h0000;
    assign commit_s    = !stream_en_r || ((h_cnt_r == 11'd0) && (v_cnt_r == V_COMMIT));
    assign visible_s   = (h_cnt_r < 11'(H_ACTIVE)) && (v_cnt_r < 10'(V_ACTIVE));
    assign hs_s        = (h_cnt_r >= 11'(H_ACTIVE + H_FP)) && (h_cnt_r < 11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_s        = (v_cnt_r >= 10'(V_ACTIVE + V_FP)) && (v_cnt_r < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign in_vblank_s = (v_cnt_r >= 10'(V_ACTIVE));
    assign vsync_set_s = stream_en_r && uo_r[7] && !vsync_d_r;
    assign vsync_clr_s = wr_word_s[1] && data_in[0];
    assign unused_s    = ^{ui_in, data_read_n, address[1:0]};

    // Shadow next-state: size-masked merge of the addressed sprite word.
    always_comb begin
        sh_wr_s = 1'b0;
        for (int n = 0; n < NUM_SPR; n++) begin
            attr_nx_s[n] = wr_word_s[4+3*n] ? (merge(attr_sh_r[n], data_in, wmask_s) & ATTR_MASK)
                                            : attr_sh_r[n];
            lo_nx_s[n]   = wr_word_s[5+3*n] ? merge(lo_sh_r[n], data_in, wmask_s) : lo_sh_r[n];
            hi_nx_s[n]   = wr_word_s[6+3*n] ? merge(hi_sh_r[n], data_in, wmask_s) : hi_sh_r[n];
            sh_wr_s      = sh_wr_s | wr_word_s[4+3*n] | wr_word_s[5+3*n] | wr_word_s[6+3*n];
        end
    end

    // Shadow registers, active copy and commit_pending; a same-cycle write rides along with the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_SPR; n++) begin
                attr_sh_r[n]  <= 32'h0000_0000;
                lo_sh_r[n]    <= 32'h0000_0000;
                hi_sh_r[n]    <= 32'h0000_0000;
                act_attr_r[n] <= 23'h00_0000;
                act_bmp_r[n]  <= 64'h0000_0000_0000_0000;
            end
            commit_pending_r <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_SPR; n++) begin
                attr_sh_r[n] <= attr_nx_s[n];
                lo_sh_r[n]   <= lo_nx_s[n];
                hi_sh_r[n]   <= hi_nx_s[n];
                if (commit_s) begin
                    act_attr_r[n] <= {attr_nx_s[n][31], attr_nx_s[n][21:0]};
                    act_bmp_r[n]  <= {hi_nx_s[n], lo_nx_s[n]};
                end
            end
            commit_pending_r <= commit_s ? 1'b0 : (commit_pending_r | sh_wr_s);
        end
    end

    // Control bits and the vsync flag (a set event beats a simultaneous W1C).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream_en_r    <= 1'b0;
            vsync_irq_en_r <= 1'b0;
            vsync_flag_r   <= 1'b0;
        end else begin
            if (wr_word_s[0]) begin
                stream_en_r    <= data_in[0];
                vsync_irq_en_r <= data_in[1];
            end
            vsync_flag_r <= vsync_set_s | (vsync_flag_r & ~vsync_clr_s);
        end
    end

    // Beam counters; held at the origin while streaming is off so re-enable starts at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 10'd0;
        end else if (!stream_en_r) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    // Sprite hit test in logical pixels; later (higher-index) sprites override earlier ones.
    always_comb begin
        lx_s  = 9'(h_cnt_r >> SCALE_LOG2);
        ly_s  = 9'(v_cnt_r >> SCALE_LOG2);
        rgb_s = 6'h00;
        hit_s = {NUM_SPR{1'b0}};
        for (int n = 0; n < NUM_SPR; n++) begin
            dx_s[n]  = lx_s - {1'b0, act_attr_r[n][7:0]};
            dy_s[n]  = ly_s - {1'b0, act_attr_r[n][15:8]};
            hit_s[n] = act_attr_r[n][22] && (dx_s[n] < 9'd8) && (dy_s[n] < 9'd8)
                       && act_bmp_r[n][{dy_s[n][2:0], dx_s[n][2:0]}];
            rgb_s    = hit_s[n] ? act_attr_r[n][21:16] : rgb_s;
        end
    end

    assign pix_rgb_s = visible_s ? rgb_s : 6'h00;

    // Registered video output and the delayed vsync used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_r      <= 8'h00;
            vsync_d_r <= 1'b0;
        end else begin
            uo_r      <= stream_en_r ? {vs_s, hs_s, pix_rgb_s} : 8'h00;
            vsync_d_r <= uo_r[7];
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic               coll_irq_en_r, coll_flag_r, coll_set_s, coll_clr_s;
    logic [NUM_SPR-1:0] coll_r;
    logic [2:0]         hit_cnt_s;

    // Count simultaneous hits on the current pixel.
    always_comb begin
        hit_cnt_s = 3'd0;
        for (int n = 0; n < NUM_SPR; n++) begin
            hit_cnt_s = hit_cnt_s + {2'b00, hit_s[n]};
        end
    end

    assign coll_set_s = stream_en_r && visible_s && (hit_cnt_s >= 3'd2);
    assign coll_clr_s = wr_word_s[1] && data_in[1];

    // Sticky collision mask and flag; clearing the flag also clears the mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_irq_en_r <= 1'b0;
            coll_flag_r   <= 1'b0;
            coll_r        <= {NUM_SPR{1'b0}};
        end else begin
            if (wr_word_s[0]) begin
                coll_irq_en_r <= data_in[2];
            end
            coll_flag_r <= coll_set_s | (coll_flag_r & ~coll_clr_s);
            if (coll_set_s) begin
                coll_r <= coll_r | hit_s;
            end else if (coll_clr_s) begin
                coll_r <= {NUM_SPR{1'b0}};
            end
        end
    end

    assign coll_flag_s   = coll_flag_r;
    assign coll_irq_en_s = coll_irq_en_r;
    assign coll_mask_s   = coll_r;
`else
    assign coll_flag_s   = 1'b0;
    assign coll_irq_en_s = 1'b0;
    assign coll_mask_s   = {NUM_SPR{1'b0}};
`endif

    // Read map, indexed by word address; unmapped words read 0.
    always_comb begin
        for (int w = 0; w < 16; w++) begin
            reg_word_s[w] = 32'h0000_0000;
        end
        reg_word_s[0] = {29'h0, coll_irq_en_s, vsync_irq_en_r, stream_en_r};
        reg_word_s[1] = {28'h0, commit_pending_r, in_vblank_s, coll_flag_s, vsync_flag_r};
        reg_word_s[2] = 32'(coll_mask_s);
        for (int n = 0; n < NUM_SPR; n++) begin
            reg_word_s[4+3*n] = attr_sh_r[n];
            reg_word_s[5+3*n] = lo_sh_r[n];
            reg_word_s[6+3*n] = hi_sh_r[n];
        end
    end

    assign data_out       = reg_word_s[word_s];
    assign data_ready     = 1'b1;
    assign uo_out         = uo_r;
    assign user_interrupt = (vsync_flag_r & vsync_irq_en_r) | (coll_flag_s & coll_irq_en_s);
endmodule
